pipe_stage_sequencer: RTL and testbench

//  Central pipeline-enable sequencer for the 5-stage RV32I core. Merges load-use/branch stall

---
 rtl/pipe_stage_sequencer.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_sequencer.sv
// rtl/pipe_stage_sequencer.sv - pipeline enable/flush sequencer with debug halt/step and perf counters
module pipe_stage_sequencer #(
  parameter int CNT_W        = 32,
  parameter int MEM_TIMEOUT  = 255,
  parameter bit START_HALTED = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hz_pc_en,
  input  logic             hz_if_id_en,
  input  logic             hz_id_ex_clr,
  input  logic             br_flush,
  input  logic             dm_req,
  input  logic             dm_ready,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  input  logic             dbg_resume,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] memwait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(MEM_TIMEOUT);
  localparam logic [WAIT_W:0] WAIT_ONE  = (WAIT_W + 1)'(1);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT, S_STEP} state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_memwait_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_freeze;
  logic              w_hold;
  logic              w_adv;
  logic              w_flush;
  logic              w_stall_ev;
  logic [WAIT_W:0]   w_wait_nxt;
  logic              w_timeout;

  // HALT ignores the memory handshake; a RUN cycle that sees dbg_halt is already held.
  assign w_freeze   = dm_req & ~dm_ready & (r_state != S_HALT);
  assign w_hold     = (r_state == S_HALT) | ((r_state == S_RUN) & dbg_halt);
  assign w_adv      = ~w_freeze & ~w_hold;
  assign w_flush    = w_adv & br_flush;
  assign w_stall_ev = w_adv & ~br_flush & ~hz_pc_en;

  // The RUN cycle that first freezes counts as wait cycle one.
  assign w_wait_nxt = (r_state == S_MEM_WAIT) ? ({1'b0, r_wait} + WAIT_ONE) : WAIT_ONE;
  assign w_timeout  = (MEM_TIMEOUT != 0) && (w_wait_nxt >= TIMEOUT_V);

  assign pc_en     = w_adv & (br_flush | hz_pc_en);
  assign if_id_en  = w_adv & (br_flush | hz_if_id_en);
  assign id_ex_en  = w_adv;
  assign ex_mem_en = w_adv;
  assign mem_wb_en = w_adv;
  assign if_id_clr = w_flush;
  assign id_ex_clr = w_adv & (br_flush | hz_id_ex_clr);
  assign halted    = (r_state == S_HALT);
  assign mem_err   = r_mem_err;

  assign stall_cnt   = r_stall_cnt;
  assign memwait_cnt = r_memwait_cnt;
  assign flush_cnt   = r_flush_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= START_HALTED ? S_HALT : S_RUN;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        S_RUN, S_MEM_WAIT: begin
          if (w_freeze) begin
            if (w_timeout) begin
              r_mem_err <= 1'b1;
              r_state   <= S_HALT;
              r_wait    <= '0;
            end else begin
              r_state <= S_MEM_WAIT;
              r_wait  <= w_wait_nxt[WAIT_W-1:0];
            end
          end else begin
            r_wait  <= '0;
            r_state <= dbg_halt ? S_HALT : S_RUN;
          end
        end
        S_HALT: begin
          if (dbg_resume) begin
            r_state <= S_RUN;
          end else if (dbg_step) begin
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          if (!w_freeze) begin
            r_state <= S_HALT;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] f_cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic clr);
    if (clr) begin
      return '0;
    end else if (inc && (c != '1)) begin
      return c + CNT_W'(1);
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt   <= '0;
      r_memwait_cnt <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_stall_cnt   <= f_cnt_next(r_stall_cnt, w_stall_ev, cnt_clr);
      r_memwait_cnt <= f_cnt_next(r_memwait_cnt, w_freeze, cnt_clr);
      r_flush_cnt   <= f_cnt_next(r_flush_cnt, w_flush, cnt_clr);
    end
  end

endmodule

// File: tb/tb_pipe_stage_sequencer.sv
// tb/tb_pipe_stage_sequencer.sv - scoreboard bench for pipe_stage_sequencer
module tb_pipe_stage_sequencer;

  localparam int CNT_W = 4;
  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] NONE = 5'b00000;

  logic clk = 1'b0;
  logic rstn;
  logic hz_pc_en, hz_if_id_en, hz_id_ex_clr, br_flush, dm_req, dm_ready;
  logic dbg_halt, dbg_step, dbg_resume, cnt_clr;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr, halted, mem_err;
  logic [CNT_W-1:0] stall_cnt, memwait_cnt, flush_cnt;

  pipe_stage_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .START_HALTED(1'b0)) dut (
    .clk(clk), .rstn(rstn),
    .hz_pc_en(hz_pc_en), .hz_if_id_en(hz_if_id_en), .hz_id_ex_clr(hz_id_ex_clr),
    .br_flush(br_flush), .dm_req(dm_req), .dm_ready(dm_ready),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step), .dbg_resume(dbg_resume), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr),
    .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .memwait_cnt(memwait_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       en;
    logic [1:0]       clr;
    logic             hlt;
    logic             err;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] mw;
    logic [CNT_W-1:0] fl;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_vec = 0;
  logic [CNT_W-1:0] e_st, e_mw, e_fl;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_idle();
    hz_pc_en = 1'b1; hz_if_id_en = 1'b1; hz_id_ex_clr = 1'b0; br_flush = 1'b0;
    dm_req = 1'b0; dm_ready = 1'b0; dbg_halt = 1'b0; dbg_step = 1'b0;
    dbg_resume = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  function automatic logic [CNT_W-1:0] sat_up(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && c != {CNT_W{1'b1}}) ? c + 1'b1 : c;
  endfunction

  // Push expectation for the current cycle; si/mi/fi say which counter this cycle should bump.
  task automatic expect_cyc(input logic [4:0] en, input logic [1:0] clr, input logic hlt,
                            input logic err, input logic si, input logic mi, input logic fi,
                            input logic cc);
    exp_t e;
    e.en = en; e.clr = clr; e.hlt = hlt; e.err = err;
    e.st = e_st; e.mw = e_mw; e.fl = e_fl;
    q.push_back(e);
    if (cc) begin
      e_st = '0; e_mw = '0; e_fl = '0;
    end else begin
      e_st = sat_up(e_st, si); e_mw = sat_up(e_mw, mi); e_fl = sat_up(e_fl, fi);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_vec++;
      check_eq($sformatf("en#%0d", n_vec), {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e.en});
      check_eq($sformatf("clr#%0d", n_vec), {30'd0, if_id_clr, id_ex_clr}, {30'd0, e.clr});
      check_eq($sformatf("halted#%0d", n_vec), {31'd0, halted}, {31'd0, e.hlt});
      check_eq($sformatf("mem_err#%0d", n_vec), {31'd0, mem_err}, {31'd0, e.err});
      check_eq($sformatf("stall_cnt#%0d", n_vec), {28'd0, stall_cnt}, {28'd0, e.st});
      check_eq($sformatf("memwait_cnt#%0d", n_vec), {28'd0, memwait_cnt}, {28'd0, e.mw});
      check_eq($sformatf("flush_cnt#%0d", n_vec), {28'd0, flush_cnt}, {28'd0, e.fl});
    end
  end

  initial begin
    e_st = '0; e_mw = '0; e_fl = '0;
    rstn = 1'b0;
    set_idle();
    @(posedge clk); #1;
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);
    tick(); rstn = 1'b1;
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);

    tick(); hz_pc_en = 0; hz_if_id_en = 0; hz_id_ex_clr = 1;
    expect_cyc(5'b00111, 2'b01, 0, 0, 1, 0, 0, 0);
    tick();
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);

    tick(); br_flush = 1; hz_pc_en = 0;
    expect_cyc(ALL, 2'b11, 0, 0, 0, 0, 1, 0);
    tick();
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);

    // Three frozen cycles; flush/stall requests under freeze must not count.
    tick(); dm_req = 1;
    expect_cyc(NONE, 2'b00, 0, 0, 0, 1, 0, 0);
    tick(); dm_req = 1; br_flush = 1; hz_pc_en = 0;
    expect_cyc(NONE, 2'b00, 0, 0, 0, 1, 0, 0);
    tick(); dm_req = 1;
    expect_cyc(NONE, 2'b00, 0, 0, 0, 1, 0, 0);
    tick(); dm_req = 1; dm_ready = 1;
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);

    // Halt entry cycle is held; a branch in it is dropped.
    tick(); dbg_halt = 1; br_flush = 1;
    expect_cyc(NONE, 2'b00, 0, 0, 0, 0, 0, 0);
    tick(); dbg_halt = 1;
    expect_cyc(NONE, 2'b00, 1, 0, 0, 0, 0, 0);
    tick(); dbg_halt = 1; dbg_step = 1;
    expect_cyc(NONE, 2'b00, 1, 0, 0, 0, 0, 0);
    tick(); dbg_halt = 1; hz_pc_en = 0;
    expect_cyc(5'b01111, 2'b00, 0, 0, 1, 0, 0, 0);
    tick(); dbg_halt = 1;
    expect_cyc(NONE, 2'b00, 1, 0, 0, 0, 0, 0);
    tick(); dbg_step = 1;
    expect_cyc(NONE, 2'b00, 1, 0, 0, 0, 0, 0);
    tick();
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    expect_cyc(NONE, 2'b00, 1, 0, 0, 0, 0, 0);
    tick(); dbg_resume = 1; dbg_step = 1;
    expect_cyc(NONE, 2'b00, 1, 0, 0, 0, 0, 0);
    tick();
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);
    tick(); dbg_step = 1;
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);
    tick(); dbg_resume = 1;
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);

    tick(); cnt_clr = 1; hz_pc_en = 0;
    expect_cyc(5'b01111, 2'b00, 0, 0, 1, 0, 0, 1);
    tick();
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      tick(); hz_pc_en = 0;
      expect_cyc(5'b01111, 2'b00, 0, 0, 1, 0, 0, 0);
    end
    tick();
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);

    // Stuck memory: four wait cycles then sticky mem_err and HALT.
    for (int i = 0; i < 4; i++) begin
      tick(); dm_req = 1;
      expect_cyc(NONE, 2'b00, 0, 0, 0, 1, 0, 0);
    end
    tick(); dm_req = 1;
    expect_cyc(NONE, 2'b00, 1, 1, 0, 0, 0, 0);
    tick(); dbg_resume = 1;
    expect_cyc(NONE, 2'b00, 1, 1, 0, 0, 0, 0);
    tick();
    expect_cyc(ALL, 2'b00, 0, 1, 0, 0, 0, 0);

    // Reset while frozen in STEP.
    tick(); dbg_halt = 1;
    expect_cyc(NONE, 2'b00, 0, 1, 0, 0, 0, 0);
    tick(); dbg_step = 1;
    expect_cyc(NONE, 2'b00, 1, 1, 0, 0, 0, 0);
    tick(); dm_req = 1;
    expect_cyc(NONE, 2'b00, 0, 1, 0, 1, 0, 0);
    tick(); rstn = 1'b0;
    e_st = '0; e_mw = '0; e_fl = '0;
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);
    tick(); rstn = 1'b1;
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    expect_cyc(ALL, 2'b00, 0, 0, 0, 0, 0, 0);

    @(negedge clk); #1;
    check_eq("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
